// File: rtl/harvard_download_sequencer_if.sv
// harvard_download_sequencer_if: byte stream in, instruction RAM write port out
interface harvard_download_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  modport master (output in_data, in_valid, input in_ready, ram_we, ram_addr, ram_wdata);
  modport slave (input in_data, in_valid, output in_ready, ram_we, ram_addr, ram_wdata);
endinterface

// File: rtl/harvard_download_sequencer.sv
// harvard_download_sequencer: framed UART firmware download into user instruction RAM
module harvard_download_sequencer #(
  parameter int         ADDR_W         = 10,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                         hb_clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         auto_boot,
  input  logic                         clear,
  harvard_download_sequencer_if.slave  bus,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [ADDR_W:0]              words_written,
  output logic                         boot_req
);
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic              in_ready_q, busy_q, done_q, err_q, ram_we_q, boot_req_q, boot_pend_q;
  logic [1:0]        err_code_q, err_code_d, byte_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q, shift_q;
  logic [15:0]       len_q, len_full;
  logic [7:0]        sum_q;
  logic [TW-1:0]     tmo_q;
  logic              acc, active, tmo_hit, last_word;
  assign bus.in_ready   = in_ready_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_code       = err_code_q;
  assign words_written  = words_q;
  assign boot_req       = boot_req_q;
  // Next state: enable drop beats an accepted byte, which beats the timeout
  always_comb begin
    acc        = bus.in_valid && in_ready_q;
    active     = state_q inside {LEN_LO, LEN_HI, DATA, CHECK};
    tmo_hit    = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    len_full   = {bus.in_data, len_q[7:0]};
    last_word  = 16'(words_q) + 16'd1 == len_q;
    state_d    = state_q;
    err_code_d = err_code_q;
    if (active && !enable) state_d = IDLE;
    else if (acc)
      case (state_q)
        IDLE:   state_d = (enable && bus.in_data == SYNC_BYTE) ? LEN_LO : IDLE;
        LEN_LO: state_d = LEN_HI;
        LEN_HI: begin
          state_d    = 32'(len_full) > DEPTH ? ERROR : (len_full == 16'd0 ? CHECK : DATA);
          err_code_d = 32'(len_full) > DEPTH ? 2'd1 : err_code_q;
        end
        DATA:   state_d = (byte_q == 2'd3 && last_word) ? CHECK : DATA;
        CHECK: begin
          state_d    = bus.in_data == sum_q ? DONE : ERROR;
          err_code_d = bus.in_data == sum_q ? err_code_q : 2'd2;
        end
        default: ;
      endcase
    else if (active && tmo_hit) begin
      state_d    = ERROR;
      err_code_d = 2'd3;
    end
    if (clear && state_q inside {DONE, ERROR}) begin
      state_d    = IDLE;
      err_code_d = 2'd0;
    end
  end
  // State, registered status outputs and the word-assembly datapath
  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      boot_req_q  <= 1'b0;
      boot_pend_q <= 1'b0;
      words_q     <= '0;
      byte_q      <= 2'd0;
      shift_q     <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= !(state_d inside {DONE, ERROR});
      busy_q      <= state_d inside {LEN_LO, LEN_HI, DATA, CHECK};
      done_q      <= state_d == DONE;
      err_q       <= state_d == ERROR;
      err_code_q  <= err_code_d;
      ram_we_q    <= 1'b0;
      boot_req_q  <= boot_pend_q;
      boot_pend_q <= state_d == DONE && state_q != DONE && auto_boot;
      tmo_q       <= (acc || !active) ? '0 : tmo_q + 1'b1;
      if (acc && enable)
        case (state_q)
          IDLE:
            if (bus.in_data == SYNC_BYTE) begin
              sum_q   <= '0;
              words_q <= '0;
              byte_q  <= 2'd0;
              shift_q <= '0;
            end
          LEN_LO: len_q[7:0] <= bus.in_data;
          LEN_HI: len_q[15:8] <= bus.in_data;
          DATA: begin
            shift_q <= {bus.in_data, shift_q[31:8]};
            sum_q   <= sum_q + bus.in_data;
            byte_q  <= byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              ram_we_q    <= 1'b1;
              ram_addr_q  <= words_q[ADDR_W-1:0];
              ram_wdata_q <= {bus.in_data, shift_q[31:8]};
              words_q     <= words_q + 1'b1;
            end
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_harvard_download_sequencer.sv
// tb_harvard_download_sequencer: directed frames with a RAM-write scoreboard
module tb_harvard_download_sequencer;
  localparam int AW = 4;
  typedef struct {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  logic hb_clk = 1'b0, rst_n = 1'b0, enable = 1'b0, auto_boot = 1'b0, clear = 1'b0;
  logic busy, done, err, boot_req;
  logic [1:0] err_code;
  logic [AW:0] words_written;
  int total = 0, bad = 0, boot_cnt = 0;
  logic [7:0] sum;
  wr_t exp_q[$];
  wr_t mon_x;
  harvard_download_sequencer_if #(.ADDR_W(AW)) bus ();
  harvard_download_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(50), .SYNC_BYTE(8'hA5)) dut (
    .hb_clk(hb_clk), .rst_n(rst_n), .enable(enable), .auto_boot(auto_boot), .clear(clear),
    .bus(bus), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .words_written(words_written), .boot_req(boot_req)
  );
  always #5 hb_clk = ~hb_clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge hb_clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    bus.in_data = b;
    bus.in_valid = 1'b1;
    @(posedge hb_clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w);
    exp_q.push_back('{a, w});
    for (int j = 0; j < 4; j++) begin
      send(w[8*j +: 8]);
      sum = sum + w[8*j +: 8];
    end
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  // Scoreboard: every RAM write must match the oldest expected write
  always @(negedge hb_clk) begin
    if (bus.ram_we) begin
      chk("ram_we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_x = exp_q.pop_front();
        chk("ram_addr", 32'(bus.ram_addr), 32'(mon_x.a));
        chk("ram_wdata", bus.ram_wdata, mon_x.d);
      end
    end
    if (boot_req) boot_cnt++;
  end
  initial begin
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    @(negedge hb_clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    enable = 1'b1;
    auto_boot = 1'b1;
    // good frame with leading junk and auto boot
    send(8'h00);
    send(8'hFF);
    @(negedge hb_clk);
    chk("junk_busy", 32'(busy), 32'd0);
    tick();
    send(8'hA5);
    send(8'h02);
    send(8'h00);
    sum = 8'h00;
    send_word(4'd0, 32'h0000_0013);
    send_word(4'd1, 32'h0000_006F);
    send(8'h82);
    @(negedge hb_clk);
    chk("ok_done", 32'(done), 32'd1);
    chk("ok_err", 32'(err), 32'd0);
    chk("ok_words", 32'(words_written), 32'd2);
    chk("ok_in_ready", 32'(bus.in_ready), 32'd0);
    chk("ok_boot_entry", 32'(boot_req), 32'd0);
    @(negedge hb_clk);
    chk("ok_boot_pulse", 32'(boot_req), 32'd1);
    @(negedge hb_clk);
    chk("ok_boot_end", 32'(boot_req), 32'd0);
    chk("ok_boot_cnt", 32'(boot_cnt), 32'd1);
    chk("ok_queue", 32'(exp_q.size()), 32'd0);
    tick();
    do_clear();
    @(negedge hb_clk);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_words_kept", 32'(words_written), 32'd2);
    tick();
    // same frame, bad checksum
    send(8'hA5);
    send(8'h02);
    send(8'h00);
    sum = 8'h00;
    send_word(4'd0, 32'h0000_0013);
    send_word(4'd1, 32'h0000_006F);
    send(8'h83);
    @(negedge hb_clk);
    chk("cks_err", 32'(err), 32'd1);
    chk("cks_code", 32'(err_code), 32'd2);
    chk("cks_done", 32'(done), 32'd0);
    @(negedge hb_clk);
    @(negedge hb_clk);
    chk("cks_no_boot", 32'(boot_cnt), 32'd1);
    tick();
    do_clear();
    @(negedge hb_clk);
    chk("cks_clr_err", 32'(err), 32'd0);
    chk("cks_clr_code", 32'(err_code), 32'd0);
    tick();
    // length 17 exceeds 16-word RAM
    send(8'hA5);
    send(8'h11);
    send(8'h00);
    @(negedge hb_clk);
    chk("len_err", 32'(err), 32'd1);
    chk("len_code", 32'(err_code), 32'd1);
    chk("len_busy", 32'(busy), 32'd0);
    tick();
    do_clear();
    // length equal to depth fills the RAM
    auto_boot = 1'b0;
    send(8'hA5);
    send(8'h10);
    send(8'h00);
    sum = 8'h00;
    for (int i = 0; i < 16; i++) send_word(AW'(i), {8'(i), 8'hC0, 8'(i * 3), 8'(i + 1)});
    send(sum);
    @(negedge hb_clk);
    chk("full_done", 32'(done), 32'd1);
    chk("full_words", 32'(words_written), 32'd16);
    @(negedge hb_clk);
    @(negedge hb_clk);
    chk("full_no_boot", 32'(boot_cnt), 32'd1);
    chk("full_queue", 32'(exp_q.size()), 32'd0);
    tick();
    do_clear();
    // zero-length frame
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    @(negedge hb_clk);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_words_cleared", 32'(words_written), 32'd0);
    tick();
    send(8'h00);
    @(negedge hb_clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_words", 32'(words_written), 32'd0);
    tick();
    do_clear();
    // timeout after 5 data bytes
    send(8'hA5);
    send(8'h05);
    send(8'h00);
    sum = 8'h00;
    send_word(4'd0, 32'h0403_0201);
    send(8'h05);
    repeat (49) @(posedge hb_clk);
    @(negedge hb_clk);
    chk("tmo_not_yet", 32'(err), 32'd0);
    @(posedge hb_clk);
    @(negedge hb_clk);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_code", 32'(err_code), 32'd3);
    chk("tmo_busy", 32'(busy), 32'd0);
    tick();
    do_clear();
    // byte arriving on the timeout cycle wins
    send(8'hA5);
    send(8'h05);
    send(8'h00);
    send(8'h11);
    repeat (49) @(posedge hb_clk);
    #1;
    send(8'h22);
    @(negedge hb_clk);
    chk("tmo_rescue_err", 32'(err), 32'd0);
    chk("tmo_rescue_busy", 32'(busy), 32'd1);
    // enable drop mid-DATA
    enable = 1'b0;
    tick();
    @(negedge hb_clk);
    chk("endrop_busy", 32'(busy), 32'd0);
    chk("endrop_err", 32'(err), 32'd0);
    chk("endrop_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    // sync byte dropped while disabled
    send(8'hA5);
    @(negedge hb_clk);
    chk("dis_sync_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    // asynchronous reset mid-DATA
    send(8'hA5);
    send(8'h02);
    send(8'h00);
    sum = 8'h00;
    send_word(4'd0, 32'hDEAD_BEEF);
    send(8'h6F);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_words", 32'(words_written), 32'd0);
    chk("arst_ram_we", 32'(bus.ram_we), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/harvard_download_sequencer.md
Name: harvard_download_sequencer

Overview:
- Sequences a firmware download into the user instruction RAM while the core runs the bootloader ROM.
- Consumes a framed byte stream from the debug UART: sync byte, 16-bit word count, little-endian instruction words, then an 8-bit checksum.
- Writes each assembled word to the user instruction RAM write port, reports status, and can request the BOOT→NORMAL switch on success.
- Sits beside the boot/download controller in the system peripheral cluster.

Parameters:
- ADDR_W, 10, user instruction RAM word-address width; DEPTH = 2**ADDR_W words.
- TIMEOUT_CYCLES, 1000000, idle hb_clk cycles allowed between bytes inside a frame.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- hb_clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, download mode active (driven from download_mode).
- auto_boot, input, 1, request a boot switch on successful completion.
- clear, input, 1, return from DONE/ERROR to IDLE.
- in_data, input, 8, received byte.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, sequencer accepts a byte; a byte transfers when in_valid && in_ready.
- ram_we, output, 1, one-cycle write strobe to user instruction RAM.
- ram_addr, output, ADDR_W, word address.
- ram_wdata, output, 32, instruction word.
- busy, output, 1, a frame is in progress.
- done, output, 1, last frame succeeded (sticky until clear).
- err, output, 1, last frame failed (sticky until clear).
- err_code, output, 2, 0 none, 1 length, 2 checksum, 3 timeout.
- words_written, output, ADDR_W+1, words written in the current or last frame.
- boot_req, output, 1, one-cycle pulse; the system writes 8'hF0 to the boot debug register.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0 except in_ready=1; all counters, sum and shift register 0.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- in_ready: 1 in IDLE through CHECK; 0 in DONE and ERROR.
- IDLE: an accepted byte equal to SYNC_BYTE while enable=1 → LEN_LO and clear sum/word/byte counters. Other bytes are accepted and dropped. busy=0.
- LEN_LO: accepted byte → len[7:0], go to LEN_HI.
- LEN_HI: accepted byte → len[15:8]. Then:
  - len > DEPTH → ERROR, err_code=1.
  - len == 0 → CHECK.
  - otherwise → DATA.
- busy=1 in LEN_LO, LEN_HI, DATA, CHECK.
- DATA:
  - Bytes fill a little-endian word: byte index 0 goes to bits [7:0], index 3 to bits [31:24].
  - Each data byte is added to an 8-bit sum, modulo 256.
  - On byte index 3, the next cycle has ram_we=1, ram_addr=word_idx[ADDR_W-1:0], ram_wdata=assembled word. ram_we is exactly one cycle per word; there is no back-pressure from the RAM.
  - word_idx and words_written increment with that write.
  - After the write of word len-1 → CHECK.
- CHECK: accepted byte == sum → DONE, done=1. Otherwise → ERROR, err_code=2, err=1.
- DONE: if auto_boot=1 on entry, boot_req pulses for exactly 1 cycle, on the cycle after entry; no repeat. Stay until clear.
- ERROR: err=1; stay until clear.
- clear in DONE/ERROR → IDLE next cycle; done, err and err_code return to 0. words_written keeps its value until the next sync byte.
- Timeout: the counter resets on every accepted byte and counts only in LEN_LO..CHECK. On reaching TIMEOUT_CYCLES-1 → ERROR, err_code=3. If a byte is accepted in the same cycle, the byte wins and the counter resets.
- enable deasserted in LEN_LO..CHECK → IDLE next cycle, no error flagged, partial writes remain. enable=0 in IDLE: bytes are dropped, including SYNC_BYTE.
- Priority, highest first: rst_n, enable drop, byte acceptance, timeout.
- len == DEPTH is legal and fills the whole RAM; word_idx never wraps.

Test Plan:
- Frame A5 02 00, bytes 13 00 00 00 / 6F 00 00 00, checksum 82; auto_boot=1 → ram_we at addr 0 data 0x00000013 and addr 1 data 0x0000006F; done=1; words_written=2; boot_req one-cycle pulse.
- Same frame with checksum 83 → err=1, err_code=2, no boot_req; clear → IDLE, err=0.
- ADDR_W=4, frame A5 11 00 (len 17 > 16) → ERROR with err_code=1 right after LEN_HI; no ram_we.
- Frame A5 00 00 00 → DONE with words_written=0 and no ram_we. Leading junk 00 FF before A5 is ignored.
- TIMEOUT_CYCLES=50: stop after 5 data bytes → err_code=3 on cycle 50 after the last byte. A byte arriving on the timeout cycle prevents the timeout.
- Assert rst_n low mid-DATA → outputs cleared immediately. Drop enable mid-DATA → IDLE, busy=0, err=0.
